reflet_mem_wait_interface: RTL

//  Registered CPU-to-memory bridge with programmable wait states, optional external ready and bus timeout.

---
 rtl/reflet_mem_wait_interface_pkg.sv | 35 +++
 rtl/reflet_mem_wait_counter.sv | 41 ++++
 rtl/reflet_mem_wait_interface.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/reflet_mem_wait_interface_pkg.sv
//------------------------------------------------------------------------------
// Module   : reflet_mem_wait_interface_pkg
// Purpose  : Shared FSM encoding, counter width and error data constant for
//            the Reflet wait-state memory bridge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package reflet_mem_wait_interface_pkg;

    // Wait-state counter width; covers latencies 0..15
    localparam int WAIT_W = 4;

    // Fill bit replicated across the read data bus when an access is aborted
    localparam logic ERROR_FILL = 1'b1;

    // Bridge FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Stall counter width: enough bits for the timeout value, never below one
    function automatic int stall_width(input int timeout);
        if (timeout < 1) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reflet_mem_wait_counter.sv
//------------------------------------------------------------------------------
// Module   : reflet_mem_wait_counter
// Purpose  : Loadable down-counter with zero flag. Decrement saturates at
//            zero so the count never wraps.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module reflet_mem_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over decrement; the count holds at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (enable) begin
            if (load) begin
                r_count <= load_value;
            end else if (dec && (r_count != '0)) begin
                r_count <= r_count - WIDTH'(1);
            end
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/reflet_mem_wait_interface.sv
//------------------------------------------------------------------------------
// Module   : reflet_mem_wait_interface
// Purpose  : Registered CPU-to-memory bridge with programmable read/write
//            wait states, optional external ready and stall timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module reflet_mem_wait_interface
    import reflet_mem_wait_interface_pkg::*;
#(
    parameter int WORDSIZE      = 16,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 0,
    parameter int USE_MEM_READY = 0,
    parameter int TIMEOUT       = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [WORDSIZE-1:0] cpu_addr,
    input  logic [WORDSIZE-1:0] cpu_data_out,
    output logic [WORDSIZE-1:0] cpu_data_in,
    input  logic                cpu_write_en,
    input  logic                cpu_read_en,
    output logic                cpu_ready,
    output logic                cpu_error,
    output logic [WORDSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_data_out,
    input  logic [WORDSIZE-1:0] mem_data_in,
    output logic                mem_write_en,
    output logic                mem_read_en,
    input  logic                mem_ready
);

    localparam int STALL_W = stall_width(TIMEOUT);

    // The stall counter is loaded with TIMEOUT-1 so that the stall seen while
    // it already reads zero is the TIMEOUT-th one, which aborts the access.
    localparam logic [STALL_W-1:0] STALL_LOAD = (TIMEOUT > 0) ? STALL_W'(TIMEOUT - 1) : '0;
    localparam logic [WAIT_W-1:0]  RL_LOAD    = WAIT_W'(READ_LATENCY);
    localparam logic [WAIT_W-1:0]  WL_LOAD    = WAIT_W'(WRITE_LATENCY);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_issue;
    logic                w_complete;
    logic                w_abort;
    logic                w_stall;
    logic                w_mem_ok;
    logic                w_wait_zero;
    logic                w_stall_zero;
    logic                w_wait_dec;
    logic [WAIT_W-1:0]   w_wait_load;

    // External ready only matters when the bus provides one
    assign w_mem_ok    = (USE_MEM_READY == 0) || mem_ready;
    // A simultaneous write and read request is treated as a write
    assign w_wait_load = cpu_write_en ? WL_LOAD : RL_LOAD;
    assign w_wait_dec  = (r_state == ST_ACCESS);

    reflet_mem_wait_counter #(
        .WIDTH      (WAIT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (w_issue),
        .load_value (w_wait_load),
        .dec        (w_wait_dec),
        .zero       (w_wait_zero)
    );

    reflet_mem_wait_counter #(
        .WIDTH      (STALL_W)
    ) u_stall_cnt (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (w_issue),
        .load_value (STALL_LOAD),
        .dec        (w_stall),
        .zero       (w_stall_zero)
    );

    // State register; frozen while enable is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else if (enable) begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus issue/complete/stall/abort strobes
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_write_en || cpu_read_en) begin
                    w_issue      = 1'b1;
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_wait_zero) begin
                    if (w_mem_ok) begin
                        w_complete   = 1'b1;
                        w_next_state = ST_DONE;
                    end else begin
                        w_stall = 1'b1;
                        if ((TIMEOUT != 0) && w_stall_zero) begin
                            w_abort      = 1'b1;
                            w_next_state = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Address and write data are captured at issue and held afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr     <= '0;
            mem_data_out <= '0;
        end else if (enable && w_issue) begin
            mem_addr     <= cpu_addr;
            mem_data_out <= cpu_data_out;
        end
    end

    // Memory strobes stay high for the whole access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
        end else if (enable) begin
            if (w_issue) begin
                mem_write_en <= cpu_write_en;
                mem_read_en  <= ~cpu_write_en;
            end else if (w_complete || w_abort) begin
                mem_write_en <= 1'b0;
                mem_read_en  <= 1'b0;
            end
        end
    end

    // Completion pulse, error flag and returned read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_data_in <= '0;
            cpu_ready   <= 1'b0;
            cpu_error   <= 1'b0;
        end else if (enable) begin
            if (w_complete) begin
                if (mem_read_en) begin
                    cpu_data_in <= mem_data_in;
                end
                cpu_ready <= 1'b1;
                cpu_error <= 1'b0;
            end else if (w_abort) begin
                cpu_data_in <= {WORDSIZE{ERROR_FILL}};
                cpu_ready   <= 1'b1;
                cpu_error   <= 1'b1;
            end else if (r_state == ST_DONE) begin
                cpu_ready <= 1'b0;
                cpu_error <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
